// File: rtl/cdb_arbiter_pkg.sv
// Shared types and defaults for the write-back arbiter and the dispatch stage.
package cdb_arbiter_pkg;
  localparam int CDB_NUM_FU = 4;
  localparam int CDB_ROB_IX = 2;
  localparam int CDB_DATA_W = 32;
  localparam int CDB_FU_W   = $clog2(CDB_NUM_FU);

  typedef struct packed {
    logic                  valid;
    logic [CDB_FU_W-1:0]   fu;
    logic [CDB_ROB_IX:0]   rob_ix;
    logic [CDB_DATA_W-1:0] data;
  } cdb_entry_t;
endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Rotate-priority picker: first request at or after ptr (wrapping) wins.
module cdb_arbiter_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_in,
  input  logic [W-1:0] ptr_in,
  output logic [N-1:0] gnt_out,
  output logic [W-1:0] idx_out,
  output logic         any_out
);
  always_comb begin
    gnt_out = '0;
    idx_out = '0;
    any_out = 1'b0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = (int'(ptr_in) + i) % N;
      if (req_in[j] && !any_out) begin
        any_out    = 1'b1;
        gnt_out[j] = 1'b1;
        idx_out    = W'(j);
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// Moves at most one functional-unit result per cycle into a registered CDB slot.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = CDB_NUM_FU,
  parameter int ROB_IX = CDB_ROB_IX,
  parameter int DATA_W = CDB_DATA_W,
  parameter int FU_W   = $clog2(NUM_FU)
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       flush_in,
  input  logic [NUM_FU-1:0]          fu_valid_in,
  input  logic [NUM_FU*DATA_W-1:0]   fu_data_in,
  input  logic [NUM_FU*(ROB_IX+1)-1:0] fu_rob_ix_in,
  output logic [NUM_FU-1:0]          fu_read_out,
  input  logic                       cdb_ready_in,
  output logic                       cdb_valid_out,
  output logic [DATA_W-1:0]          cdb_data_out,
  output logic [ROB_IX:0]            cdb_rob_ix_out,
  output logic [FU_W-1:0]            cdb_fu_out
);
  typedef struct packed {
    logic              valid;
    logic [FU_W-1:0]   fu;
    logic [ROB_IX:0]   rob_ix;
    logic [DATA_W-1:0] data;
  } slot_t;

  slot_t             slot_q, slot_d;
  logic [FU_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_FU-1:0] mask_q, mask_d;

  logic              slot_free;
  logic              grant_en;
  logic [NUM_FU-1:0] pick_gnt;
  logic [FU_W-1:0]   pick_idx;
  logic              pick_any;
  logic              grant;

  cdb_arbiter_rr_pick #(.N(NUM_FU), .W(FU_W)) u_pick (
    .req_in  (fu_valid_in & ~mask_q),
    .ptr_in  (rr_ptr_q),
    .gnt_out (pick_gnt),
    .idx_out (pick_idx),
    .any_out (pick_any)
  );

  // Handshake: a result moves when the FU is valid and we pulse its read
  // strobe; the slot moves when cdb_valid_out and cdb_ready_in are both high.
  assign slot_free   = !slot_q.valid || cdb_ready_in;
  assign grant_en    = slot_free && !flush_in && rst_in;
  assign grant       = grant_en && pick_any;
  assign fu_read_out = grant ? pick_gnt : '0;

  always_comb begin
    slot_d   = slot_q;
    rr_ptr_d = rr_ptr_q;
    mask_d   = '0;
    if (flush_in) begin
      slot_d.valid = 1'b0;
    end else if (grant) begin
      slot_d.valid  = 1'b1;
      slot_d.fu     = pick_idx;
      slot_d.data   = fu_data_in[int'(pick_idx)*DATA_W +: DATA_W];
      slot_d.rob_ix = fu_rob_ix_in[int'(pick_idx)*(ROB_IX+1) +: (ROB_IX+1)];
      rr_ptr_d      = (pick_idx == FU_W'(NUM_FU-1)) ? '0 : pick_idx + 1'b1;
      // The granted FU keeps valid high one more cycle; mask it out then.
      mask_d        = pick_gnt;
    end else if (cdb_ready_in && slot_q.valid) begin
      slot_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      slot_q   <= '0;
      rr_ptr_q <= '0;
      mask_q   <= '0;
    end else begin
      slot_q   <= slot_d;
      rr_ptr_q <= rr_ptr_d;
      mask_q   <= mask_d;
    end
  end

  assign cdb_valid_out  = slot_q.valid;
  assign cdb_data_out   = slot_q.data;
  assign cdb_rob_ix_out = slot_q.rob_ix;
  assign cdb_fu_out     = slot_q.fu;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter with an integer-level reference model.
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int RI = 2;
  localparam int DW = 32;
  localparam int FW = 2;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              flush_in;
  logic [N-1:0]      fu_valid_in;
  logic [N*DW-1:0]   fu_data_in;
  logic [N*(RI+1)-1:0] fu_rob_ix_in;
  logic [N-1:0]      fu_read_out;
  logic              cdb_ready_in;
  logic              cdb_valid_out;
  logic [DW-1:0]     cdb_data_out;
  logic [RI:0]       cdb_rob_ix_out;
  logic [FW-1:0]     cdb_fu_out;

  cdb_arbiter #(.NUM_FU(N), .ROB_IX(RI), .DATA_W(DW), .FU_W(FW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
    .fu_valid_in(fu_valid_in), .fu_data_in(fu_data_in), .fu_rob_ix_in(fu_rob_ix_in),
    .fu_read_out(fu_read_out), .cdb_ready_in(cdb_ready_in),
    .cdb_valid_out(cdb_valid_out), .cdb_data_out(cdb_data_out),
    .cdb_rob_ix_out(cdb_rob_ix_out), .cdb_fu_out(cdb_fu_out)
  );

  always #5 clk_in = ~clk_in;

  // FU side: results held until read, dropped one edge after the read edge.
  logic [DW-1:0] fu_dat [N];
  logic [RI:0]   fu_rob [N];
  bit            fu_drop [N];

  always_comb begin
    fu_data_in   = '0;
    fu_rob_ix_in = '0;
    for (int i = 0; i < N; i++) begin
      fu_data_in[i*DW +: DW]           = fu_dat[i];
      fu_rob_ix_in[i*(RI+1) +: (RI+1)] = fu_rob[i];
    end
  end

  // Reference model of the slot and arbitration state.
  int          m_ptr;
  bit [N-1:0]  m_mask;
  bit          m_valid;
  logic [DW-1:0] m_data;
  logic [RI:0] m_rob;
  int          m_fu;
  logic [N-1:0] obs_rd;
  logic [FW-1:0] exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic m_reset();
    m_ptr = 0; m_mask = '0; m_valid = 0; m_data = '0; m_rob = '0; m_fu = 0;
  endtask

  function automatic int exp_grant();
    if (!rst_in || flush_in || (m_valid && !cdb_ready_in)) return -1;
    for (int i = 0; i < N; i++) begin
      int j;
      j = (m_ptr + i) % N;
      if (fu_valid_in[j] && !m_mask[j]) return j;
    end
    return -1;
  endfunction

  task automatic fu_advance(input int g);
    for (int j = 0; j < N; j++) begin
      if (fu_drop[j]) begin fu_valid_in[j] = 1'b0; fu_drop[j] = 0; end
      if (g == j) fu_drop[j] = 1;
    end
  endtask

  task automatic set_fu(input int k, input logic [DW-1:0] d, input logic [RI:0] r);
    fu_valid_in[k] = 1'b1; fu_dat[k] = d; fu_rob[k] = r;
  endtask

  // One clock cycle: check the strobe, clock the edge, check the slot.
  task automatic step();
    int g;
    logic [N-1:0] exp_rd;
    #2;
    g = exp_grant();
    exp_rd = (g >= 0) ? (N'(1) << g) : '0;
    obs_rd = fu_read_out;
    n_tests++;
    if (fu_read_out !== exp_rd) begin
      n_fail++; $display("FAIL read_strobe t=%0t got=%b exp=%b", $time, fu_read_out, exp_rd);
    end
    @(posedge clk_in);
    if (flush_in) begin
      m_valid = 0; m_mask = '0;
    end else if (g >= 0) begin
      m_valid = 1; m_data = fu_dat[g]; m_rob = fu_rob[g]; m_fu = g;
      m_ptr = (g + 1) % N; m_mask = N'(1) << g;
    end else begin
      m_mask = '0;
      if (cdb_ready_in && m_valid) m_valid = 0;
    end
    #1;
    fu_advance(g);
    n_tests++;
    if ({cdb_valid_out, cdb_data_out, cdb_rob_ix_out, cdb_fu_out} !==
        {m_valid, m_data, m_rob, FW'(m_fu)}) begin
      n_fail++;
      $display("FAIL cdb_slot t=%0t got=%b/%h/%0d/%0d exp=%b/%h/%0d/%0d", $time,
               cdb_valid_out, cdb_data_out, cdb_rob_ix_out, cdb_fu_out,
               m_valid, m_data, m_rob, m_fu);
    end
  endtask

  task automatic check_zero(input string name);
    n_tests++;
    if ({fu_read_out, cdb_valid_out, cdb_data_out, cdb_rob_ix_out, cdb_fu_out} !== '0) begin
      n_fail++;
      $display("FAIL %s got rd=%b v=%b d=%h r=%0d f=%0d exp all zero", name,
               fu_read_out, cdb_valid_out, cdb_data_out, cdb_rob_ix_out, cdb_fu_out);
    end
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    #1;
    m_reset();
    @(posedge clk_in); #1;
    fu_advance(-1);
    @(posedge clk_in); #1;
    fu_advance(-1);
    rst_in = 1'b1;
  endtask

  task automatic test_reset();
    rst_in = 1'b0; flush_in = 0; cdb_ready_in = 1;
    fu_valid_in = '0;
    for (int i = 0; i < N; i++) begin fu_drop[i] = 0; set_fu(i, 32'hA0 + i, RI'(i)); end
    m_reset();
    @(posedge clk_in); #1;
    check_zero("reset_state");
    fu_valid_in = '0;
    rst_in = 1'b1;
  endtask

  task automatic test_single();
    set_fu(2, 32'h1234, 3'd5);
    step();
    n_tests++;
    if (obs_rd !== 4'b0100) begin n_fail++; $display("FAIL single_read got=%b exp=0100", obs_rd); end
    n_tests++;
    if ({cdb_valid_out, cdb_data_out, cdb_rob_ix_out, cdb_fu_out} !== {1'b1, 32'h1234, 3'd5, 2'd2}) begin
      n_fail++; $display("FAIL single_cdb got=%b/%h/%0d/%0d exp=1/1234/5/2",
                         cdb_valid_out, cdb_data_out, cdb_rob_ix_out, cdb_fu_out);
    end
    step();
    n_tests++;
    if (obs_rd !== 4'b0000) begin n_fail++; $display("FAIL single_no_repeat got=%b exp=0000", obs_rd); end
  endtask

  task automatic test_wrap();
    set_fu(3, 32'h3333, 3'd3);
    set_fu(0, 32'h0000_0F0F, 3'd0);
    exp_q = '{2'd3, 2'd0};
    for (int c = 0; c < 2; c++) begin
      step();
      n_tests++;
      if (obs_rd !== (N'(1) << exp_q[c])) begin
        n_fail++; $display("FAIL wrap_order c=%0d got=%b exp_fu=%0d", c, obs_rd, exp_q[c]);
      end
    end
    step();
    set_fu(0, 32'h55, 3'd1);
    set_fu(1, 32'h66, 3'd2);
    step();
    n_tests++;
    if (obs_rd !== 4'b0010) begin n_fail++; $display("FAIL wrap_ptr got=%b exp=0010", obs_rd); end
    step(); step(); step();
  endtask

  task automatic test_all_four();
    do_reset();
    for (int i = 0; i < N; i++) set_fu(i, 32'hC0DE_0000 + i, RI'(7 - i));
    for (int c = 0; c < N; c++) begin
      step();
      n_tests++;
      if (obs_rd !== (N'(1) << c) || cdb_valid_out !== 1'b1) begin
        n_fail++; $display("FAIL all_four c=%0d got rd=%b v=%b exp rd=%b v=1", c, obs_rd, cdb_valid_out, N'(1) << c);
      end
    end
    step();
    n_tests++;
    if (obs_rd !== '0) begin n_fail++; $display("FAIL all_four_tail got=%b exp=0000", obs_rd); end
    step();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held;
    set_fu(0, 32'hBEEF, 3'd4);
    step();
    held = cdb_data_out;
    set_fu(1, 32'h1111, 3'd1);
    set_fu(3, 32'h3131, 3'd3);
    cdb_ready_in = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_tests++;
      if (obs_rd !== '0 || cdb_valid_out !== 1'b1 || cdb_data_out !== 32'hBEEF) begin
        n_fail++; $display("FAIL backpressure c=%0d got rd=%b v=%b d=%h exp rd=0000 v=1 d=beef",
                           c, obs_rd, cdb_valid_out, cdb_data_out);
      end
    end
    cdb_ready_in = 1;
    step();
    n_tests++;
    if (obs_rd !== 4'b0010 || cdb_data_out !== 32'h1111) begin
      n_fail++; $display("FAIL bp_release got rd=%b d=%h exp rd=0010 d=1111", obs_rd, cdb_data_out);
    end
    step(); step(); step();
  endtask

  task automatic test_flush_consume();
    set_fu(2, 32'h2222, 3'd2);
    step();
    set_fu(0, 32'hF00D, 3'd6);
    flush_in = 1;
    step();
    n_tests++;
    if (obs_rd !== '0 || cdb_valid_out !== 1'b0) begin
      n_fail++; $display("FAIL flush got rd=%b v=%b exp rd=0000 v=0", obs_rd, cdb_valid_out);
    end
    flush_in = 0;
    step();
    n_tests++;
    if (obs_rd !== 4'b0001 || cdb_valid_out !== 1'b1 || cdb_data_out !== 32'hF00D) begin
      n_fail++; $display("FAIL after_flush got rd=%b v=%b d=%h exp rd=0001 v=1 d=f00d",
                         obs_rd, cdb_valid_out, cdb_data_out);
    end
    step(); step();
  endtask

  task automatic test_async_reset();
    set_fu(1, 32'hAAAA, 3'd1);
    set_fu(2, 32'hBBBB, 3'd2);
    step();
    #2;
    rst_in = 1'b0;
    #1;
    check_zero("async_reset");
    m_reset();
    @(posedge clk_in); #1;
    fu_advance(-1);
    rst_in = 1'b1;
    step();
    n_tests++;
    if (obs_rd !== 4'b0100 || cdb_data_out !== 32'hBBBB) begin
      n_fail++; $display("FAIL reset_keeps got rd=%b d=%h exp rd=0100 d=bbbb", obs_rd, cdb_data_out);
    end
    step(); step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int j = 0; j < N; j++)
        if (!fu_valid_in[j] && $urandom_range(1, 0) == 1)
          set_fu(j, $urandom, RI'($urandom_range(7, 0)));
      cdb_ready_in = ($urandom_range(3, 0) != 0);
      flush_in     = ($urandom_range(15, 0) == 0);
      step();
    end
    flush_in = 0; cdb_ready_in = 1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_all_four();
    test_backpressure();
    test_flush_consume();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Write-back arbiter for the superscalar core. It is the reading end of the functional-unit result handshake: it watches the `valid_out` / `data_out` / `rob_ix_out` of up to `NUM_FU` units and pulses their `read_in`. It moves at most one result per cycle into a registered common-data-bus (CDB) slot. That slot broadcasts to the ROB and reservation stations, with backpressure from the ROB.

## Interface
- `NUM_FU`, default 4: number of functional units served (≥2).
- `ROB_IX`, default 2: ROB index MSB; index width is `ROB_IX+1`.
- `DATA_W`, default 32: result width.
- `FU_W`, default `$clog2(NUM_FU)`: grant index width.

Ports:
- `clk_in`  input  1  sole clock, rising edge.
- `rst_in`  input  1  asynchronous, active-low reset.
- `flush_in`  input  1  synchronous pipeline flush.
- `fu_valid_in`  input  `NUM_FU`  per-FU result valid; held until read.
- `fu_data_in`  input  `NUM_FU`×`DATA_W`  per-FU result.
- `fu_rob_ix_in`  input  `NUM_FU`×(`ROB_IX+1`)  per-FU destination ROB index.
- `fu_read_out`  output  `NUM_FU`  one-hot read strobe; combinational.
- `cdb_ready_in`  input  1  ROB consumes the CDB slot this cycle.
- `cdb_valid_out`  output  1  CDB slot holds a result.
- `cdb_data_out`  output  `DATA_W`  broadcast result.
- `cdb_rob_ix_out`  output  `ROB_IX+1`  broadcast ROB index.
- `cdb_fu_out`  output  `FU_W`  source FU of the broadcast.

## Operation
- Slot free: `!cdb_valid_out || cdb_ready_in`.
- Grant eligibility: requires slot free, `!flush_in` and `rst_in` high.
- Grant selection:
  - Eligible FUs are `fu_valid_in & ~mask`.
  - Search starts at `rr_ptr` and wraps modulo `NUM_FU`.
  - The first eligible FU wins. At most one `fu_read_out` bit is high.
- `fu_read_out` is combinational from `fu_valid_in`, `rr_ptr`, `mask`, slot state and `flush_in`. It has no path from `fu_data_in`.
- On a grant of FU k at an edge:
  - Slot loads `fu_data_in[k]` and `fu_rob_ix_in[k]`, sets `cdb_fu_out=k` and `cdb_valid_out=1`.
  - `rr_ptr` becomes (k+1) mod `NUM_FU`.
  - `mask` becomes one-hot k.
- On an edge with no grant:
  - `mask` clears to 0.
  - `rr_ptr` is unchanged.
  - If `cdb_ready_in && cdb_valid_out`, then `cdb_valid_out` becomes 0. Data fields hold their last value.
- `mask` guards against a double read. FUs drop `valid_out` one cycle after sampling `read_in`, so without it the granted FU could be picked again the next cycle.
- Backpressure: while `cdb_valid_out && !cdb_ready_in`, the slot and `rr_ptr` hold and no `fu_read_out` is asserted. FU results wait in place.
- `flush_in`: on that edge `cdb_valid_out` is cleared, no grant is made and `mask` clears. `rr_ptr` holds. Pending FU results are not read; the ROB discards them by index.

## Timing
- Reset (`rst_in` low, asynchronous) clears:
  - `cdb_valid_out`, `cdb_data_out`, `cdb_rob_ix_out`, `cdb_fu_out`;
  - `rr_ptr` and `mask`.
  - `fu_read_out` is forced to 0 while reset is held.
- Reset mid-operation: the slot contents are lost. FUs that saw no read strobe keep their results.
- Latency:
  - An FU valid in cycle t with the slot free gets `fu_read_out` in cycle t.
  - Its result appears on the CDB in cycle t+1.
- Throughput is one result per cycle when `cdb_ready_in` is held high.
- Simultaneous events:
  - Consume and grant on the same edge: the slot reloads with no bubble.
  - Flush and consume on the same edge: the flush dominates.
- Wrap-around: a grant of FU `NUM_FU-1` sets `rr_ptr=0`.

## Structure
- `types.svh` gains:
  - a `cdb_entry_t` packed struct {valid, fu, rob_ix, data};
  - a `NUM_FU` default constant shared with dispatch.
- Sub-module `rr_pick`: a purely combinational rotate-priority one-hot picker (request vector, pointer → one-hot grant and index). It is reused later by issue select.
- The top level holds the CDB register, `rr_ptr`, `mask` and the handshake logic.

## Test plan
- Single result: FU2 valid with rob_ix=5, data=0x1234, rr_ptr=0, ready=1. Expect `fu_read_out=0100` in that cycle. Next cycle expect CDB valid with 0x1234 / 5 / fu 2, and `rr_ptr=3`.
- All four FUs valid from reset with ready=1. Expect grants in order 0,1,2,3 on four consecutive cycles, each FU dropping valid after its read. Expect no repeat grant and CDB valid for four cycles.
- Backpressure: hold ready=0 for 3 cycles with FU1 and FU3 pending. Expect no `fu_read_out`, the CDB held stable, then grant FU1 on the cycle ready returns to 1.
- Wrap: rr_ptr=3 with FU3 and FU0 valid. Expect FU3 granted, then FU0, and rr_ptr ending at 1.
- Flush and consume together with FU0 pending. Expect CDB valid 0 next cycle, FU0 not read that cycle, and a grant the following cycle.
- Async reset pulse mid-stream. Expect all CDB outputs and `fu_read_out` at 0 immediately, without waiting for a clock edge.
